// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies LEN bytes from {src,8'h00} into OAM after a write
// to the DMA register. Drives a single bus-master port, one beat at a time.
module oam_dma_ctrl #(
  parameter logic [15:0] REG_ADDR    = 16'hFF46,
  parameter logic [15:0] OAM_BASE    = 16'hFE00,
  parameter int          LEN         = 160,
  parameter int          START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  input  logic        m_ack,
  output logic        dma_active,
  output logic        dma_done
);

  typedef enum logic [1:0] {IDLE, DELAY, RD, WR} state_t;

  localparam logic [7:0] LAST_IDX    = 8'(LEN - 1);
  localparam logic [3:0] DELAY_INIT  = 4'(START_DELAY);
  localparam state_t     START_STATE = (START_DELAY == 0) ? RD : DELAY;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  run_src_q, run_src_d;
  logic [7:0]  data_q, data_d;
  logic        pend_q, pend_d;
  logic        done_q, done_d;
  logic        trig;
  logic        restart;

  // Echo RAM pages (E0..FF) fold back onto work RAM (C0..DF).
  function automatic logic [7:0] eff_src(input logic [7:0] s);
    return (s >= 8'hE0) ? (s & 8'hDF) : s;
  endfunction

  assign trig = reg_wr && (reg_addr == REG_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      src_q     <= '0;
      run_src_q <= '0;
      data_q    <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      src_q     <= src_d;
      run_src_q <= run_src_d;
      data_q    <= data_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    run_src_d = run_src_q;
    data_d    = data_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    restart   = 1'b0;
    src_d     = trig ? reg_wdata : src_q;

    case (state_q)
      IDLE: begin
        if (trig) restart = 1'b1;
      end
      DELAY: begin
        if (trig) begin
          restart = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d = RD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD: begin
        if (m_ack) begin
          data_d = m_rdata;
          if (trig || pend_q) restart = 1'b1;
          else                state_d = WR;
        end else if (trig) begin
          pend_d = 1'b1;
        end
      end
      WR: begin
        // A retrigger seen during the beat (or on its ack) beats completion.
        if (m_ack) begin
          if (trig || pend_q) begin
            restart = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = RD;
          end
        end else if (trig) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      state_d   = START_STATE;
      cnt_d     = DELAY_INIT;
      idx_d     = 8'd0;
      pend_d    = 1'b0;
      run_src_d = eff_src(src_d);
    end
  end

  always_comb begin
    m_req      = 1'b0;
    m_we       = 1'b0;
    m_addr     = 16'h0000;
    m_wdata    = 8'h00;
    dma_active = (state_q != IDLE);
    dma_done   = done_q;
    reg_rdata  = (reg_rd && (reg_addr == REG_ADDR)) ? src_q : 8'h00;
    case (state_q)
      RD: begin
        m_req  = 1'b1;
        m_addr = {run_src_q, 8'h00} + {8'h00, idx_q};
      end
      WR: begin
        m_req   = 1'b1;
        m_we    = 1'b1;
        m_addr  = OAM_BASE + {8'h00, idx_q};
        m_wdata = data_q;
      end
      default: ;
    endcase
  end

endmodule
